// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg: shared state type, byte width and counter sizing for the word serializer.
package word_serializer_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam int BYTE_W = 8;
    function automatic int cnt_w(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction
endpackage

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: unloads a WIDTH-bit word one byte per handshake, MSB byte first.
// Defining SERIALIZER_LSB_FIRST_EN emits the least-significant byte first instead.
module word_byte_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int NBYTES = WIDTH / BYTE_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy
);
    localparam int CW = cnt_w(NBYTES);
    if (WIDTH % BYTE_W != 0 || WIDTH < 16) begin : g_bad_width
        $error("WIDTH must be a multiple of 8 and at least 16");
    end
    state_t state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, shifted;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BYTE_W-1:0] head;
    logic send, last;
`ifdef SERIALIZER_LSB_FIRST_EN
    assign head    = sr_q[BYTE_W-1:0];
    assign shifted = sr_q >> BYTE_W;
`else
    assign head    = sr_q[WIDTH-1 -: BYTE_W];
    assign shifted = sr_q << BYTE_W;
`endif
    assign send      = state_q == SEND;
    assign last      = send && (cnt_q == CW'(NBYTES - 1));
    assign out_valid = send;
    assign busy      = send;
    assign out_last  = last;
    assign out_data  = send ? head : '0;
    // out_ready -> in_ready is the sole combinational path; it enables zero-bubble reloads.
    assign in_ready  = !send || (last && out_ready);
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        if (!send && in_valid) begin
            sr_d    = in_data;
            cnt_d   = '0;
            state_d = SEND;
        end else if (send && out_ready) begin
            if (!last) begin
                sr_d  = shifted;
                cnt_d = cnt_q + CW'(1);
            end else if (in_valid) begin
                sr_d  = in_data;
                cnt_d = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_word_byte_serializer.sv
// tb_word_byte_serializer: directed table, hand sequences and randomized scoreboard for word_byte_serializer.
module tb_word_byte_serializer;
    logic        clock = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    int checks = 0;
    int failures = 0;

    word_byte_serializer #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]      word;
        logic [3:0][7:0]  msb_order;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // i-th emitted byte of a word in the build's order
    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
`ifdef SERIALIZER_LSB_FIRST_EN
        return 8'((w >> (8 * i)) & 32'hFF);
`else
        return 8'((w >> (8 * (3 - i))) & 32'hFF);
`endif
    endfunction

    // 32-bit register with a byte shift-in load on FunSel 110
    function automatic logic [31:0] reg32(input logic [31:0] q, input logic e, input logic [2:0] fs, input logic [7:0] d);
        if (!e || fs != 3'b110) return q;
`ifdef SERIALIZER_LSB_FIRST_EN
        return {d, q[31:8]};
`else
        return {q[23:0], d};
`endif
    endfunction

    task automatic send_word(input string n, input logic [31:0] w, input logic [3:0][7:0] mo);
        @(negedge clock);
        in_valid = 1; in_data = w; out_ready = 1;
        #1 chk({n, "_accept_ready"}, in_ready, 1);
        @(negedge clock);
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk({n, "_valid"}, out_valid, 1);
`ifdef SERIALIZER_LSB_FIRST_EN
            chk({n, "_data"}, out_data, mo[i]);
`else
            chk({n, "_data"}, out_data, mo[3 - i]);
`endif
            chk({n, "_last"}, out_last, i == 3);
            @(negedge clock);
        end
        #1;
        chk({n, "_idle_ready"}, in_ready, 1);
        chk({n, "_idle_busy"}, busy, 0);
        chk({n, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        vec_t tbl[3];
        logic [8:0] q[$];
        logic [31:0] r;
        logic pat[7];
        int idx;
        logic m_ready;
        tbl[0] = '{32'hDEADBEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
        tbl[1] = '{32'hCAFEF00D, {8'hCA, 8'hFE, 8'hF0, 8'h0D}};
        tbl[2] = '{32'h00FF7F80, {8'h00, 8'hFF, 8'h7F, 8'h80}};

        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clock); reset = 0;

        for (int k = 0; k < 3; k++) send_word($sformatf("tbl%0d", k), tbl[k].word, tbl[k].msb_order);

        // backpressure: ready pattern 1,0,0,1,0,1,1
        pat = '{1, 0, 0, 1, 0, 1, 1};
        @(negedge clock);
        in_valid = 1; in_data = 32'h12345678; out_ready = 0;
        @(negedge clock);
        in_valid = 0; idx = 0;
        for (int k = 0; k < 7; k++) begin
            out_ready = pat[k];
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, exp_byte(32'h12345678, idx));
            chk("bp_last", out_last, idx == 3);
            if (pat[k]) idx++;
            @(negedge clock);
        end
        #1 chk("bp_done_busy", busy, 0);

        // back-to-back with in_valid held across the boundary
        @(negedge clock);
        in_valid = 1; in_data = 32'h01020304; out_ready = 1;
        @(negedge clock);
        in_data = 32'hA1B2C3D4;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("b2b_valid", out_valid, 1);
            chk("b2b_data", out_data, exp_byte(i < 4 ? 32'h01020304 : 32'hA1B2C3D4, i % 4));
            chk("b2b_in_ready", in_ready, i == 3 || i == 7);
            @(negedge clock);
            if (i == 3) in_valid = 0;
        end
        #1 chk("b2b_idle", busy, 0);

        // reset asserted between edges right after the second byte transfers
        @(negedge clock);
        in_valid = 1; in_data = 32'hDEADBEEF; out_ready = 1;
        @(negedge clock);
        in_valid = 0;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clock); reset = 0;
        #1 chk("mid_rst_ready", in_ready, 1);
        send_word("post_rst", 32'hCAFEF00D, {8'hCA, 8'hFE, 8'hF0, 8'h0D});

        // round trip through the register's byte shift-in load
        r = '0;
        @(negedge clock);
        in_valid = 1; in_data = 32'h89ABCDEF; out_ready = 1;
        @(negedge clock);
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            #1 if (out_valid && out_ready) r = reg32(r, 1'b1, 3'b110, out_data);
            @(negedge clock);
        end
        chk("round_trip", r, 32'h89ABCDEF);

        // randomized traffic against a byte queue scoreboard
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            m_ready = q.size() == 0 || (q.size() == 1 && out_ready);
            chk("rnd_valid", out_valid, q.size() != 0);
            chk("rnd_in_ready", in_ready, m_ready);
            if (out_valid && q.size() != 0) begin
                chk("rnd_data", out_data, q[0][7:0]);
                chk("rnd_last", out_last, q[0][8]);
            end
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && m_ready)
                for (int i = 0; i < 4; i++) q.push_back({i == 3, exp_byte(in_data, i)});
        end
        @(negedge clock);
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            #1;
            if (out_valid) begin
                chk("drain_data", out_data, q[0][7:0]);
                void'(q.pop_front());
            end
            @(negedge clock);
        end
        chk("drain_empty", q.size(), 0);
        #1 chk("drain_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
